// File: rtl/fp_addsub_stage.sv
// fp_addsub_stage: two-stage binary64 add/sub wrapper around an external combinational adder
module fp_addsub_stage #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_a,
  input  logic [63:0]      in_b,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic [63:0]      add_a,
  output logic [63:0]      add_b,
  input  logic [63:0]      add_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic [2:0]       out_flags,
  output logic [TAG_W-1:0] out_tag
);
  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;
  logic             s1_valid;
  logic [63:0]      a, b;
  logic [TAG_W-1:0] tag;
  logic             za, zb, ia, ib, na, nb;
  logic [10:0]      emax;
  logic             s2_free, s1_adv, accept;
  logic [63:0]      b_in;
  logic [10:0]      ea_in, eb_in, sum_exp;
  logic             eff_add;
  logic [63:0]      res;
  logic [2:0]       flags;
  assign s2_free  = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_free;
  assign in_ready = !s1_valid || s2_free;
  assign accept   = in_valid && in_ready;
  assign b_in     = {in_b[63] ^ in_sub, in_b[62:0]};
  assign ea_in    = in_a[62:52];
  assign eb_in    = in_b[62:52];
  assign add_a    = a;
  assign add_b    = b;
  assign sum_exp  = add_sum[62:52];
  assign eff_add  = a[63] == b[63];
  // S1: capture operands with subtract folded into B's sign, plus operand classes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      a        <= '0;
      b        <= '0;
      tag      <= '0;
      {za, zb, ia, ib, na, nb} <= '0;
      emax     <= '0;
    end else begin
      if (accept) s1_valid <= 1'b1;
      else if (s1_adv) s1_valid <= 1'b0;
      if (accept) begin
        a    <= in_a;
        b    <= b_in;
        tag  <= in_tag;
        za   <= ea_in == 11'h000;
        zb   <= eb_in == 11'h000;
        ia   <= ea_in == 11'h7FF && in_a[51:0] == '0;
        ib   <= eb_in == 11'h7FF && in_b[51:0] == '0;
        na   <= ea_in == 11'h7FF && in_a[51:0] != '0;
        nb   <= eb_in == 11'h7FF && in_b[51:0] != '0;
        emax <= ea_in > eb_in ? ea_in : eb_in;
      end
    end
  end
  // Result selection: specials first, then adder sum with overflow/underflow overrides
  always_comb begin
    res   = add_sum;
    flags = 3'b000;
    if (na || nb) res = QNAN;
    else if (ia && ib && !eff_add) begin
      res   = QNAN;
      flags = 3'b100;
    end
    else if (ia) res = a;
    else if (ib) res = b;
    else if (za && zb) res = {a[63] & b[63], 63'd0};
    else if (za) res = b;
    else if (zb) res = a;
    else if (eff_add && emax == 11'h7FE && sum_exp == 11'h7FF) begin
      res   = {a[63], 11'h7FF, 52'd0};
      flags = 3'b010;
    end
    else if (!eff_add && add_sum[62:0] != '0 && (sum_exp > emax || sum_exp == 11'h000)) begin
      res   = {add_sum[63], 63'd0};
      flags = 3'b001;
    end
  end
  // S2: output register, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
      out_tag    <= '0;
    end else begin
      if (s2_free) out_valid <= s1_valid;
      if (s1_adv) begin
        out_result <= res;
        out_flags  <= flags;
        out_tag    <= tag;
      end
    end
  end
endmodule

// File: tb/tb_fp_addsub_stage.sv
// tb_fp_addsub_stage: scoreboard bench with a real-arithmetic reference model
module tb_fp_addsub_stage;
  localparam int TAG_W = 4;
  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] ONE  = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] TWO  = 64'h4000_0000_0000_0000;
  logic clk = 0, rst_n = 0, in_valid = 0, in_sub = 0, out_ready = 0;
  logic [63:0] in_a = 0, in_b = 0;
  logic [TAG_W-1:0] in_tag = 0;
  logic in_ready, out_valid;
  logic [63:0] add_a, add_b, add_sum, out_result;
  logic [2:0] out_flags;
  logic [TAG_W-1:0] out_tag;
  typedef struct packed {logic [63:0] r; logic [2:0] f; logic [TAG_W-1:0] t;} exp_t;
  exp_t q[$];
  int passed = 0, total = 0;
  fp_addsub_stage #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .out_tag(out_tag)
  );
  always #5 clk = ~clk;
  // stand-in for the combinational FPAdder
  assign add_sum = $realtobits($bitstoreal(add_a) + $bitstoreal(add_b));
  task automatic check(input string n, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b0, input logic sub, input logic [TAG_W-1:0] t);
    logic [63:0] b, bits;
    real s, maxd, minn;
    logic za, zb, ia, ib, na, nb;
    exp_t e;
    b = b0 ^ {sub, 63'd0};
    za = a[62:52] == 0;
    zb = b[62:52] == 0;
    ia = a[62:52] == 11'h7FF && a[51:0] == 0;
    ib = b[62:52] == 11'h7FF && b[51:0] == 0;
    na = a[62:52] == 11'h7FF && a[51:0] != 0;
    nb = b[62:52] == 11'h7FF && b[51:0] != 0;
    e.t = t;
    e.f = 3'b000;
    if (na || nb) e.r = QNAN;
    else if (ia && ib && a[63] != b[63]) begin e.r = QNAN; e.f = 3'b100; end
    else if (ia) e.r = a;
    else if (ib) e.r = b;
    else if (za && zb) e.r = {a[63] & b[63], 63'd0};
    else if (za) e.r = b;
    else if (zb) e.r = a;
    else begin
      maxd = $bitstoreal(64'h7FEF_FFFF_FFFF_FFFF);
      minn = $bitstoreal(64'h0010_0000_0000_0000);
      s = $bitstoreal(a) + $bitstoreal(b);
      bits = $realtobits(s);
      e.r = bits;
      if (s > maxd || s < -maxd) begin e.r = {bits[63], 11'h7FF, 52'd0}; e.f = 3'b010; end
      else if (a[63] != b[63] && s != 0.0 && s < minn && s > -minn) begin e.r = {bits[63], 63'd0}; e.f = 3'b001; end
    end
    return e;
  endfunction
  function automatic logic [63:0] rnd_op();
    int k;
    logic s;
    logic [63:0] r;
    k = $urandom % 12;
    s = 1'($urandom);
    r = {$urandom, $urandom};
    if (k == 0) return {s, 63'd0};
    if (k == 1) return {s, 11'h000, r[51:1], 1'b1};
    if (k == 2) return {s, 11'h7FF, 52'd0};
    if (k == 3) return {s, 11'h7FF, r[51:1], 1'b1};
    if (k < 6) return {s, 11'h7FE, r[51:0]};
    if (k == 6) return {s, 11'($urandom_range(1, 3)), r[51:0]};
    return {s, 11'($urandom_range(11'h3F0, 11'h40F)), r[51:0]};
  endfunction
  // scoreboard producer: record expectation at every accepted request
  always @(negedge clk)
    if (rst_n && in_valid && in_ready) q.push_back(model(in_a, in_b, in_sub, in_tag));
  // scoreboard consumer: presented output must match queue head, popped on handshake
  always @(negedge clk)
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_output: got %h with no expected entry", out_result);
      end else begin
        check("scoreboard", {out_result, out_flags, out_tag}, q[0]);
        if (out_ready) void'(q.pop_front());
      end
    end
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic s, input logic [TAG_W-1:0] t);
    bit acc = 0;
    in_a = a; in_b = b; in_sub = s; in_tag = t; in_valid = 1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 0;
    if (!acc) begin total++; $display("FAIL send_timeout: tag %0d not accepted, required acceptance", t); end
  endtask
  task automatic wait_drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) begin @(posedge clk); #1; end
    check("drain", q.size(), 0);
  endtask
  initial begin
    logic [63:0] sa[4], sb[4], sx[4];
    bit acc;
    sa = '{64'h7FF0_0000_0000_0000, 64'h0, 64'h8000_0000_0000_0000, 64'h7FF0_0000_0000_0001};
    sb = '{64'hFFF0_0000_0000_0000, 64'hC014_0000_0000_0000, 64'h8000_0000_0000_0000, ONE};
    sx = '{QNAN, 64'hC014_0000_0000_0000, 64'h8000_0000_0000_0000, QNAN};
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_flags", out_flags, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_add_a", add_a, 0);
    check("rst_add_b", add_b, 0);
    rst_n = 1;
    out_ready = 1;
    @(posedge clk); #1;
    send(ONE, TWO, 0, 3);
    check("latency_early", out_valid, 0);
    @(posedge clk); #1;
    check("latency_valid", out_valid, 1);
    check("basic_add", {out_result, out_flags, out_tag}, {64'h4008_0000_0000_0000, 3'b000, 4'd3});
    send(64'h3FF8_0000_0000_0000, 64'h3FF8_0000_0000_0000, 1, 4);
    @(posedge clk); #1;
    check("cancel", {out_result, out_flags}, {64'h0, 3'b000});
    for (int i = 0; i < 4; i++) begin
      send(sa[i], sb[i], i == 3, 4'(8 + i));
      if (i > 0) check("special_stream", {out_result, out_flags}, {sx[i-1], i == 1 ? 3'b100 : 3'b000});
    end
    @(posedge clk); #1;
    check("special_last", {out_result, out_flags}, {sx[3], 3'b000});
    send(64'h7FEF_FFFF_FFFF_FFFF, 64'h7FEF_FFFF_FFFF_FFFF, 0, 5);
    @(posedge clk); #1;
    check("overflow", {out_result, out_flags}, {64'h7FF0_0000_0000_0000, 3'b010});
    wait_drain();
    out_ready = 0;
    send(ONE, TWO, 0, 1);
    send(TWO, TWO, 0, 2);
    in_a = ONE; in_b = ONE; in_sub = 0; in_tag = 3; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_hold", {out_result, out_tag}, {64'h4008_0000_0000_0000, 4'd1});
      @(posedge clk); #1;
    end
    out_ready = 1;
    acc = 0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 0;
    check("bp_accept3", acc, 1);
    wait_drain();
    out_ready = 0;
    send(ONE, ONE, 0, 5);
    send(TWO, ONE, 1, 6);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1;
    out_ready = 1;
    send(ONE, TWO, 0, 7);
    @(posedge clk); #1;
    check("post_rst", {out_valid, out_result, out_tag}, {1'b1, 64'h4008_0000_0000_0000, 4'd7});
    wait_drain();
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom % 5) != 0;
        in_a = rnd_op();
        in_b = ($urandom % 4 == 0) ? {in_a[63:8], 8'($urandom)} : rnd_op();
        in_sub = 1'($urandom);
        in_tag = 4'($urandom);
      end
      out_ready = ($urandom % 4) != 0;
    end
    in_valid = 0;
    out_ready = 1;
    wait_drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
